// File: rtl/exp5_uc.sv
`default_nettype none
// ============================================================================
//  Module      : exp5_uc
//  Description : Sonar sweep control unit. Every 2 s tick it fires one
//                HC-SR04 measurement, streams the 8-char "aaa,ddd#" frame
//                over the serial TX, then advances the servo angle. Echo
//                timeouts are retried; an angle is skipped (sticky error
//                flag raised) after MAX_TENT consecutive timeouts.
//  Revision    : 1.0  initial release
// ============================================================================
module exp5_uc #(
  parameter int MAX_TENT = 3
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       ligar_i,
  input  logic       dois_segundos_i,
  input  logic       pronto_medida_i,
  input  logic       timeout_echo_i,
  input  logic       pronto_transmissao_i,
  input  logic       fim_serial_i,
  output logic       reset_circuito_o,
  output logic       medir_o,
  output logic       zera_timeout_echo_o,
  output logic       conta_timeout_echo_o,
  output logic       partida_serial_o,
  output logic       conta_ascii_o,
  output logic       conta_angulo_o,
  output logic       erro_medida_o,
  output logic       fim_posicao_o,
  output logic [3:0] db_estado_o
);

  // State codes double as the debug code on db_estado_o.
  typedef enum logic [3:0] {
    S_INICIAL     = 4'd0,
    S_PREPARA     = 4'd1,
    S_ESPERA      = 4'd2,
    S_MEDE        = 4'd3,
    S_AGUARDA_MED = 4'd4,
    S_TIMEOUT     = 4'd5,
    S_TRANSMITE   = 4'd6,
    S_AGUARDA_TX  = 4'd7,
    S_PROX_CHAR   = 4'd8,
    S_ERRO        = 4'd9,
    S_PROX_ANGULO = 4'd10
  } state_t;

  // Retry limit narrowed to the width of the attempt counter.
  localparam logic [2:0] C_MAX_TENT = 3'(MAX_TENT);

  state_t     state_q, state_d;
  logic [2:0] tentativas_q, tentativas_d;
  logic       erro_q, erro_d;
  logic [2:0] tentativas_inc_w;

  assign tentativas_inc_w = tentativas_q + 3'd1;

  // State, attempt counter and sticky error flag registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_INICIAL;
      tentativas_q <= 3'd0;
      erro_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tentativas_q <= tentativas_d;
      erro_q       <= erro_d;
    end
  end

  // Next-state logic plus attempt/error bookkeeping on specific transitions.
  always_comb begin
    state_d      = state_q;
    tentativas_d = tentativas_q;
    erro_d       = erro_q;
    case (state_q)
      S_INICIAL: begin
        if (ligar_i) state_d = S_PREPARA;
      end
      S_PREPARA: begin
        tentativas_d = 3'd0;
        erro_d       = 1'b0;
        state_d      = S_ESPERA;
      end
      // Only place (besides INICIAL) where dropping ligar takes effect, so an
      // in-flight measurement or frame is never cut short.
      S_ESPERA: begin
        if (!ligar_i)             state_d = S_INICIAL;
        else if (dois_segundos_i) state_d = S_MEDE;
      end
      S_MEDE: begin
        state_d = S_AGUARDA_MED;
      end
      // A valid measurement beats a simultaneous timeout.
      S_AGUARDA_MED: begin
        if (pronto_medida_i) begin
          tentativas_d = 3'd0;
          erro_d       = 1'b0;
          state_d      = S_TRANSMITE;
        end else if (timeout_echo_i) begin
          state_d = S_TIMEOUT;
        end
      end
      S_TIMEOUT: begin
        tentativas_d = tentativas_inc_w;
        if (tentativas_inc_w == C_MAX_TENT) state_d = S_ERRO;
        else                                state_d = S_MEDE;
      end
      S_TRANSMITE: begin
        state_d = S_AGUARDA_TX;
      end
      S_AGUARDA_TX: begin
        if (pronto_transmissao_i) state_d = S_PROX_CHAR;
      end
      // fim_serial is looked at before the selector wraps back to zero, so
      // the last character is still sent before leaving the frame loop.
      S_PROX_CHAR: begin
        if (fim_serial_i) state_d = S_PROX_ANGULO;
        else              state_d = S_TRANSMITE;
      end
      S_ERRO: begin
        erro_d       = 1'b1;
        tentativas_d = 3'd0;
        state_d      = S_PROX_ANGULO;
      end
      S_PROX_ANGULO: begin
        state_d = S_ESPERA;
      end
      default: begin
        state_d = S_INICIAL;
      end
    endcase
  end

  // Moore output decode: every strobe is a pure function of the current state.
  always_comb begin
    reset_circuito_o     = 1'b0;
    medir_o              = 1'b0;
    zera_timeout_echo_o  = 1'b0;
    conta_timeout_echo_o = 1'b0;
    partida_serial_o     = 1'b0;
    conta_ascii_o        = 1'b0;
    conta_angulo_o       = 1'b0;
    fim_posicao_o        = 1'b0;
    case (state_q)
      S_PREPARA: begin
        reset_circuito_o    = 1'b1;
        zera_timeout_echo_o = 1'b1;
      end
      S_MEDE: begin
        medir_o             = 1'b1;
        zera_timeout_echo_o = 1'b1;
      end
      S_AGUARDA_MED: conta_timeout_echo_o = 1'b1;
      S_TIMEOUT:     zera_timeout_echo_o  = 1'b1;
      S_TRANSMITE:   partida_serial_o     = 1'b1;
      S_PROX_CHAR:   conta_ascii_o        = 1'b1;
      S_PROX_ANGULO: begin
        conta_angulo_o = 1'b1;
        fim_posicao_o  = 1'b1;
      end
      default: ;
    endcase
  end

  assign erro_medida_o = erro_q;
  assign db_estado_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_exp5_uc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exp5_uc
//  Description : Scoreboard bench for exp5_uc. Stimulus pushes the expected
//                strobe records; a monitor pops one whenever the DUT shows
//                any strobe and compares state code, error flag and strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_exp5_uc;

  logic       clock = 1'b0;
  logic       reset, ligar, dois, pronto_med, timeout, pronto_tx;
  logic       fim_serial;
  logic       reset_c, medir, zera, conta_te, partida, conta_ascii;
  logic       conta_ang, erro, fim_pos;
  logic [3:0] estado;

  int tests = 0;
  int fails = 0;

  logic [12:0] exp_q[$];
  logic [2:0]  sel_q;

  exp5_uc #(.MAX_TENT(3)) dut (
    .clock_i              (clock),
    .reset_i              (reset),
    .ligar_i              (ligar),
    .dois_segundos_i      (dois),
    .pronto_medida_i      (pronto_med),
    .timeout_echo_i       (timeout),
    .pronto_transmissao_i (pronto_tx),
    .fim_serial_i         (fim_serial),
    .reset_circuito_o     (reset_c),
    .medir_o              (medir),
    .zera_timeout_echo_o  (zera),
    .conta_timeout_echo_o (conta_te),
    .partida_serial_o     (partida),
    .conta_ascii_o        (conta_ascii),
    .conta_angulo_o       (conta_ang),
    .erro_medida_o        (erro),
    .fim_posicao_o        (fim_pos),
    .db_estado_o          (estado)
  );

  always #5 clock = ~clock;

  // Minimal model of the datapath ASCII selector that produces fim_serial.
  always @(posedge clock) begin
    if (reset_c)          sel_q <= 3'd0;
    else if (conta_ascii) sel_q <= sel_q + 3'd1;
  end
  assign fim_serial = (sel_q == 3'd7);

  // Record: {state[3:0], erro, reset_c, zera, conta_te, medir, partida,
  //          conta_ascii, conta_ang, fim_pos}, built from the state table.
  function automatic logic [12:0] rec(input logic [3:0] st, input logic er);
    logic [8:0] o;
    o = 9'd0;
    o[8] = er;
    case (st)
      4'd1:  begin o[7] = 1'b1; o[6] = 1'b1; end
      4'd3:  begin o[4] = 1'b1; o[6] = 1'b1; end
      4'd4:  o[5] = 1'b1;
      4'd5:  o[6] = 1'b1;
      4'd6:  o[3] = 1'b1;
      4'd8:  o[2] = 1'b1;
      4'd10: begin o[1] = 1'b1; o[0] = 1'b1; end
      default: ;
    endcase
    return {st, o};
  endfunction

  logic [12:0] act_w;
  assign act_w = {estado, erro, reset_c, zera, conta_te, medir, partida,
                  conta_ascii, conta_ang, fim_pos};

  // Monitor: every cycle with a strobe consumes one expected record.
  always @(negedge clock) begin
    if (reset_c | zera | medir | partida | conta_ascii | conta_ang | fim_pos) begin
      tests = tests + 1;
      if (exp_q.size() == 0) begin
        fails = fails + 1;
        $display("FAIL unexpected_strobe: got %h required none", act_w);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        if (act_w !== e) begin
          fails = fails + 1;
          $display("FAIL strobe_record: got %h required %h", act_w, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] a, input logic [15:0] e);
    tests = tests + 1;
    if (a !== e) begin
      fails = fails + 1;
      $display("FAIL %s: got %h required %h", name, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input logic [3:0] st, input int max);
    int n;
    n = 0;
    while (estado !== st && n < max) begin
      tick();
      n++;
    end
    if (estado !== st) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL wait_state: got %h required %h", estado, st);
    end
  endtask

  task automatic push_frame();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(rec(4'd6, 1'b0));
      exp_q.push_back(rec(4'd8, 1'b0));
    end
  endtask

  // Answer 8 characters; ligar drops just before character drop_at.
  task automatic run_frame(input int drop_at);
    for (int i = 0; i < 8; i++) begin
      if (i == drop_at) ligar = 1'b0;
      wait_state(4'd7, 20);
      tick();
      pronto_tx = 1'b1; tick(); pronto_tx = 1'b0;
    end
  endtask

  // n timeouts followed by a finishing event (0 none, 1 pronto, 2 both).
  task automatic run_measure(input int n, input int fin);
    for (int k = 0; k < n; k++) begin
      wait_state(4'd4, 20);
      tick();
      timeout = 1'b1; tick(); timeout = 1'b0;
    end
    if (fin != 0) begin
      wait_state(4'd4, 20);
      repeat (5) tick();
      pronto_med = 1'b1;
      if (fin == 2) timeout = 1'b1;
      tick();
      pronto_med = 1'b0; timeout = 1'b0;
    end
  endtask

  task automatic fire();
    wait_state(4'd2, 20);
    tick();
    dois = 1'b1; tick(); dois = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ligar = 1'b0; dois = 1'b0; pronto_med = 1'b0;
    timeout = 1'b0; pronto_tx = 1'b0;
    tick(); tick();
    check("reset_state", {3'd0, act_w}, 16'd0);
    reset = 1'b0;

    // Normal cycle; a stray 2 s tick during the measurement is ignored.
    exp_q.push_back(rec(4'd1, 1'b0));
    exp_q.push_back(rec(4'd3, 1'b0));
    push_frame();
    exp_q.push_back(rec(4'd10, 1'b0));
    ligar = 1'b1;
    fire();
    wait_state(4'd4, 20);
    dois = 1'b1; tick(); dois = 1'b0;
    run_measure(0, 1);
    run_frame(99);
    wait_state(4'd2, 20);
    check("normal_espera", {12'd0, estado}, 16'd2);
    check("normal_erro", {15'd0, erro}, 16'd0);

    // Every attempt times out: angle skipped with erro_medida raised.
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(rec(4'd3, 1'b0));
      exp_q.push_back(rec(4'd5, 1'b0));
    end
    exp_q.push_back(rec(4'd10, 1'b1));
    fire();
    run_measure(3, 0);
    wait_state(4'd2, 20);
    check("skip_erro_set", {15'd0, erro}, 16'd1);

    // Next success clears the sticky flag.
    exp_q.push_back(rec(4'd3, 1'b1));
    push_frame();
    exp_q.push_back(rec(4'd10, 1'b0));
    fire();
    run_measure(0, 1);
    run_frame(99);
    wait_state(4'd2, 20);
    check("success_clears_erro", {15'd0, erro}, 16'd0);

    // Two timeouts, then success.
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(rec(4'd3, 1'b0));
      exp_q.push_back(rec(4'd5, 1'b0));
    end
    exp_q.push_back(rec(4'd3, 1'b0));
    push_frame();
    exp_q.push_back(rec(4'd10, 1'b0));
    fire();
    run_measure(2, 1);
    run_frame(99);
    wait_state(4'd2, 20);
    check("retry_erro_low", {15'd0, erro}, 16'd0);

    // Two timeouts, then pronto+timeout together: pronto wins, no third retry.
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(rec(4'd3, 1'b0));
      exp_q.push_back(rec(4'd5, 1'b0));
    end
    exp_q.push_back(rec(4'd3, 1'b0));
    push_frame();
    exp_q.push_back(rec(4'd10, 1'b0));
    fire();
    run_measure(2, 2);
    check("simul_to_transmite", {12'd0, estado}, 16'd6);
    run_frame(99);
    wait_state(4'd2, 20);
    check("simul_erro_low", {15'd0, erro}, 16'd0);

    // Success without prior timeouts after the simultaneous case: still no error.
    exp_q.push_back(rec(4'd3, 1'b0));
    push_frame();
    exp_q.push_back(rec(4'd10, 1'b0));
    fire();
    run_measure(0, 1);
    // ligar dropped during char 3: the frame still completes.
    run_frame(2);
    wait_state(4'd10, 20);
    check("drop_prox_angulo", {12'd0, estado}, 16'd10);
    tick();
    check("drop_espera", {12'd0, estado}, 16'd2);
    tick();
    check("drop_inicial", {12'd0, estado}, 16'd0);

    // Reset in the middle of a character transmission.
    exp_q.push_back(rec(4'd1, 1'b0));
    exp_q.push_back(rec(4'd3, 1'b0));
    exp_q.push_back(rec(4'd6, 1'b0));
    ligar = 1'b1;
    fire();
    run_measure(0, 1);
    wait_state(4'd7, 20);
    exp_q.push_back(rec(4'd1, 1'b0));
    reset = 1'b1;
    tick();
    check("midtx_reset", {3'd0, act_w}, 16'd0);
    reset = 1'b0;
    tick();
    check("post_reset_prepara", {12'd0, estado}, 16'd1);
    ligar = 1'b0;
    repeat (4) tick();
    check("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
